// File: rtl/md_sequencer_pkg.sv
// Shared definitions for the E-stage multiply/divide sequencer:
// operation encodings, FSM states and default latencies.
package md_sequencer_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    // Busy-cycle counter width; latencies are limited to 1..31.
    localparam int unsigned MD_CNT_W = 5;

    // Default latencies, also quoted by the hazard unit.
    localparam int unsigned MD_MULT_CYCLES_DEF = 5;
    localparam int unsigned MD_DIV_CYCLES_DEF  = 10;

    // Divide-class operations share the upper encoding bit.
    function automatic logic md_is_div(input md_op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/md_sequencer_if.sv
// Bus between the E-stage controller and the multiply/divide sequencer.
interface md_sequencer_if;

    logic        start;
    logic [1:0]  md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wd;
    logic        d_mdop;
    logic        busy;
    logic        done;
    logic        stall_md;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, md_op, a, b, mthi, mtlo, wd, d_mdop,
        input  busy, done, stall_md, hi, lo
    );

    modport slave (
        input  start, md_op, a, b, mthi, mtlo, wd, d_mdop,
        output busy, done, stall_md, hi, lo
    );

endinterface

// File: rtl/md_sequencer_datapath.sv
// Combinational multiply/divide of the latched operands, plus the
// zero-divisor flag used to suppress the HI/LO commit.
module md_datapath
    import md_sequencer_pkg::*;
(
    input  md_op_e      op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        div_zero_o
);

    logic        signed_op;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] prod;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_safe;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    // Signed division runs on magnitudes so that 0x80000000 / -1 yields
    // 0x80000000 rem 0 without relying on overflow behaviour of '/'.
    always_comb begin
        signed_op = (op_i == MD_MULT) || (op_i == MD_DIV);

        a_ext = signed_op ? {{32{a_i[31]}}, a_i} : {32'h0, a_i};
        b_ext = signed_op ? {{32{b_i[31]}}, b_i} : {32'h0, b_i};
        prod  = a_ext * b_ext;

        a_neg  = signed_op & a_i[31];
        b_neg  = signed_op & b_i[31];
        a_mag  = a_neg ? (32'h0 - a_i) : a_i;
        b_mag  = b_neg ? (32'h0 - b_i) : b_i;
        b_safe = (b_mag == 32'h0) ? 32'h1 : b_mag;
        q_mag  = a_mag / b_safe;
        r_mag  = a_mag % b_safe;
        quot   = (a_neg ^ b_neg) ? (32'h0 - q_mag) : q_mag;
        rem    = a_neg ? (32'h0 - r_mag) : r_mag;

        div_zero_o = md_is_div(op_i) && (b_i == 32'h0);

        if (md_is_div(op_i)) begin
            hi_o = rem;
            lo_o = quot;
        end else begin
            hi_o = prod[63:32];
            lo_o = prod[31:0];
        end
    end

endmodule

// File: rtl/md_sequencer.sv
// HI/LO multiply/divide sequencer: latches operands on start, stays busy
// for a fixed per-operation latency, commits HI/LO and pulses done.
// Also services mthi/mtlo and drives the decode-stage stall request.
module md_sequencer
    import md_sequencer_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic            clk,
    input  logic            reset,
    md_sequencer_if.slave   bus
);

    localparam logic [MD_CNT_W-1:0] MULT_LOAD = MD_CNT_W'(MULT_CYCLES);
    localparam logic [MD_CNT_W-1:0] DIV_LOAD  = MD_CNT_W'(DIV_CYCLES);

    md_state_e           state_q;
    logic [MD_CNT_W-1:0] cnt_q;
    logic                busy_q;
    logic                done_q;
    logic [31:0]         hi_q;
    logic [31:0]         lo_q;
    logic [31:0]         a_q;
    logic [31:0]         b_q;
    md_op_e              op_q;

    logic [31:0]         res_hi;
    logic [31:0]         res_lo;
    logic                div_zero;

    md_datapath u_datapath (
        .op_i       (op_q),
        .a_i        (a_q),
        .b_i        (b_q),
        .hi_o       (res_hi),
        .lo_o       (res_lo),
        .div_zero_o (div_zero)
    );

    // FSM, busy counter, operand latches and HI/LO registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= MD_MULT;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        op_q    <= md_op_e'(bus.md_op);
                        cnt_q   <= md_is_div(md_op_e'(bus.md_op)) ? DIV_LOAD : MULT_LOAD;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end else if (bus.mthi) begin
                        hi_q <= bus.wd;
                    end else if (bus.mtlo) begin
                        lo_q <= bus.wd;
                    end
                end
                ST_RUN: begin
                    if (cnt_q == MD_CNT_W'(1)) begin
                        if (!div_zero) begin
                            hi_q <= res_hi;
                            lo_q <= res_lo;
                        end
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - MD_CNT_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Outputs; stall is deliberately unregistered so the hazard unit sees
    // a start in the same cycle.
    always_comb begin
        bus.busy     = busy_q;
        bus.done     = done_q;
        bus.hi       = hi_q;
        bus.lo       = lo_q;
        bus.stall_md = bus.d_mdop & (busy_q | bus.start);
    end

endmodule

// File: doc/md_sequencer.md
# md_sequencer

Multi-cycle sequencer for the HI/LO multiply/divide resource in the E stage of the pipelined CPU. Latches operands on a start pulse from the E-stage controller, holds `busy` for a fixed per-operation latency, then commits the result to HI/LO. Also services mthi/mtlo writes and raises the decode-stage stall request when an md-class instruction in D must wait for the unit.

## Interface

Parameters:
- `MULT_CYCLES`, default 5: busy cycles for mult/multu; legal range 1..31.
- `DIV_CYCLES`, default 10: busy cycles for div/divu; legal range 1..31.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state immediately.
- `start`  in  1  E-stage mult/multu/div/divu is valid this cycle.
- `md_op`  in  2  operation: 00 mult, 01 multu, 10 div, 11 divu.
- `a`  in  32  rs operand, already forwarded.
- `b`  in  32  rt operand, already forwarded.
- `mthi`  in  1  E-stage mthi is valid this cycle.
- `mtlo`  in  1  E-stage mtlo is valid this cycle.
- `wd`  in  32  data for mthi/mtlo.
- `d_mdop`  in  1  D-stage instruction is md-class (mult/div/mfhi/mflo/mthi/mtlo).
- `busy`  out  1  operation in flight.
- `done`  out  1  one-cycle pulse in the cycle after HI/LO commit.
- `stall_md`  out  1  stall request to the hazard unit.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation

- FSM states:
  - IDLE. `start` sampled → RUN. Latches `a`, `b` and `md_op`; loads counter with MULT_CYCLES or DIV_CYCLES.
  - RUN. Counter decrements each edge. At the edge where the counter equals 1: commit HI/LO, → IDLE, set `done`.
- Result arithmetic, on latched operands:
  - mult: signed 32×32→64; hi = [63:32], lo = [31:0].
  - multu: same, unsigned.
  - div: lo = quotient truncated toward zero; hi = remainder, with the sign of the dividend.
  - divu: unsigned quotient and remainder.
- Boundary rules:
  - Divide by zero (latched b == 0): commit suppressed and HI/LO unchanged. Busy/done timing is identical to a normal divide.
  - div 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
- mthi/mtlo in IDLE: write `wd` into hi/lo at the next edge. No busy, no done.
- Same-cycle priority: `start` > `mthi` > `mtlo`. Lower-priority requests are dropped.
- In RUN, `start`, `mthi` and `mtlo` are ignored. The hazard unit prevents these through `stall_md`.
- `stall_md = d_mdop & (busy | start)`, combinational.
- Reset asserted (low) at any time, including mid-RUN: state IDLE, counter 0, busy 0, done 0, hi 0, lo 0, latched operands 0. The in-flight result is discarded.
- Reset values: busy 0, done 0, stall_md = 0 whenever d_mdop is 0, hi 0x00000000, lo 0x00000000.

## Timing

- `start` sampled at edge E0. `busy` = 1 during exactly N cycles following E0 (N = MULT_CYCLES or DIV_CYCLES).
- HI/LO take the new value at edge EN, at the same moment `busy` falls.
- `done` = 1 for the single cycle following EN.
- mfhi/mflo issued in E in the cycle after EN read the new value, with no extra bubble.
- Back-to-back: a new `start` may be sampled at edge EN+1, the first IDLE cycle. There is no dead cycle beyond that.
- mthi/mtlo latency: 1 edge.
- `stall_md` is combinational on inputs and `busy`, with no added register.

## Structure

- Shared CPU package holds:
  - the `md_op` encodings as named constants;
  - the FSM state encoding;
  - default latency constants, reused by the hazard unit for documentation.
- Counter width: 5 bits.
- One natural sub-module: `md_datapath`. It is the combinational signed/unsigned multiply/divide of the latched operands, with the zero-divisor flag. The sequencer owns the FSM, counter, operand latches and HI/LO registers.

## Test plan

- Reset release then mult with a=0xFFFFFFFE (−2), b=3 → busy high 5 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFFA at E5; done pulses once.
- multu with a=0xFFFFFFFF, b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001 after 5 cycles.
- div with a=−7 (0xFFFFFFF9), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF after 10 cycles. divu with b=0, prior hi/lo=0x11/0x22 → unchanged after 10 busy cycles, done still pulses.
- d_mdop=1 with start=1 → stall_md=1 that cycle and through all busy cycles, 0 in the cycle after EN. mthi 0xDEAD while busy → ignored; hi holds the commit value.
- mthi and mtlo in the same IDLE cycle, wd=0x1234 → hi=0x1234, lo unchanged. start with mthi in the same cycle → operation runs, hi not written by mthi.
- Reset asserted at busy cycle 3 of a div → busy, hi, lo read 0 immediately with no clock edge; after release, a new mult completes normally in 5 cycles.
